conv_host_mem: RTL and testbench

Host-side responder for the CONV accelerator's memory interface. It holds the 64x64 input image and the five layer memory banks selected by `csel`, and services the accelerator's image reads, layer writes and layer reads with fixed one-cycle read latency. It also runs the `ready`/`busy` session handshake and flags protocol violations, so a CPU or testbench can load an image, start a run and read back results.

---
 rtl/conv_host_mem_pkg.sv | 50 +++++
 rtl/conv_bank_ram.sv | 39 +++
 rtl/conv_host_mem.sv | 228 ++++++++++++++++++++++
 tb/tb_conv_host_mem.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_host_mem_pkg.sv
// Shared encodings, bank geometry, session FSM states and err bit positions
// for the CONV host-side memory responder.
package conv_host_mem_pkg;

    localparam int DW_DEFAULT = 20;
    localparam int AW_DEFAULT = 12;

    typedef enum logic [2:0] {
        NOCEL   = 3'd0,
        L0_MEM0 = 3'd1,
        L0_MEM1 = 3'd2,
        L1_MEM0 = 3'd3,
        L1_MEM1 = 3'd4,
        L2_MEM  = 3'd5
    } csel_e;

    localparam int NBANK     = 5;
    localparam int DEPTH_L0  = 4096;
    localparam int DEPTH_L1  = 1024;
    localparam int DEPTH_L2  = 2048;
    localparam int DEPTH_IMG = 4096;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RUN,
        S_DONE
    } state_e;

    localparam int ERR_RW_BOTH = 0;
    localparam int ERR_SEL     = 1;
    localparam int ERR_ADDR    = 2;
    localparam int ERR_IMG_WR  = 3;
    localparam int ERR_TIMEOUT = 4;

    function automatic logic sel_valid(input logic [2:0] sel);
        return (sel >= 3'(L0_MEM0)) && (sel <= 3'(L2_MEM));
    endfunction

    // Depth 0 for unmapped selects makes every address out of range.
    function automatic int unsigned bank_depth(input logic [2:0] sel);
        case (sel)
            3'(L0_MEM0), 3'(L0_MEM1): return DEPTH_L0;
            3'(L1_MEM0), 3'(L1_MEM1): return DEPTH_L1;
            3'(L2_MEM):               return DEPTH_L2;
            default:                  return 0;
        endcase
    endfunction

endpackage

// File: rtl/conv_bank_ram.sv
// Single-write, NRD-read RAM with registered read data that holds when its read
// port is idle. Reads see the old word on a same-cycle write; contents are not reset.
module conv_bank_ram #(
    parameter int DEPTH = 4096,
    parameter int DW    = 20,
    parameter int AW    = 12,
    parameter int NRD   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [NRD-1:0]           re,
    input  logic [NRD-1:0][AW-1:0]   raddr,
    output logic [NRD-1:0][DW-1:0]   rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else begin
            for (int i = 0; i < NRD; i++) begin
                if (re[i]) begin
                    rdata[i] <= mem[raddr[i]];
                end
            end
        end
    end

endmodule

// File: rtl/conv_host_mem.sv
// Host-side responder for the CONV accelerator: image + five layer banks,
// ready/busy session FSM, sticky protocol error flags and a layer write counter.
module conv_host_mem
    import conv_host_mem_pkg::*;
#(
    parameter int DW          = DW_DEFAULT,
    parameter int AW          = AW_DEFAULT,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic          clk,
    input  logic          reset,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    input  logic          img_we,
    input  logic [AW-1:0] img_addr,
    input  logic [DW-1:0] img_wdata,
    input  logic          start,
    input  logic          hst_rd,
    input  logic [2:0]    hst_sel,
    input  logic [AW-1:0] hst_addr,
    output logic [DW-1:0] hst_rdata,
    output logic          done,
    output logic [4:0]    err,
    output logic [15:0]   wr_count
);

    localparam int RW    = $clog2(TIMEOUT_CYC + 1);
    localparam int IMG_W = $clog2(DEPTH_IMG);

    state_e          state_q, state_d;
    logic [RW-1:0]   run_cnt;
    logic            timeout;

    // ---------------- accelerator / host access decode ----------------
    logic c_sel_ok, wr_in, rd_in, rd_eff;
    logic wr_ok, wr_oor, rd_ok, rd_oor;
    logic h_sel_ok, h_in, hst_ok, hst_oor;
    logic img_ok;

    assign c_sel_ok = sel_valid(csel);
    assign wr_in    = 32'(caddr_wr) < bank_depth(csel);
    assign rd_in    = 32'(caddr_rd) < bank_depth(csel);
    // A read colliding with a write is suppressed, so it is never range-checked.
    assign rd_eff   = crd && !cwr;
    assign wr_ok    = cwr && c_sel_ok && wr_in;
    assign wr_oor   = cwr && c_sel_ok && !wr_in;
    assign rd_ok    = rd_eff && c_sel_ok && rd_in;
    assign rd_oor   = rd_eff && c_sel_ok && !rd_in;

    assign h_sel_ok = sel_valid(hst_sel);
    assign h_in     = 32'(hst_addr) < bank_depth(hst_sel);
    assign hst_ok   = hst_rd && h_sel_ok && h_in;
    assign hst_oor  = hst_rd && h_sel_ok && !h_in;

    assign img_ok   = img_we && (state_q == S_IDLE || state_q == S_DONE);

    // ---------------- memories ----------------
    logic [0:0][IMG_W-1:0] img_raddr;
    logic [0:0][DW-1:0]    img_rdata;

    assign img_raddr[0] = iaddr[IMG_W-1:0];
    assign idata        = img_rdata[0];

    conv_bank_ram #(
        .DEPTH (DEPTH_IMG),
        .DW    (DW),
        .AW    (IMG_W),
        .NRD   (1)
    ) u_img (
        .clk   (clk),
        .reset (reset),
        .we    (img_ok),
        .waddr (img_addr[IMG_W-1:0]),
        .wdata (img_wdata),
        .re    (1'b1),
        .raddr (img_raddr),
        .rdata (img_rdata)
    );

    logic [DW-1:0] acc_q [NBANK];
    logic [DW-1:0] hst_q [NBANK];

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        localparam int          BD  = int'(bank_depth(3'(b + 1)));
        localparam int          BW  = $clog2(BD);
        localparam logic [2:0]  SEL = 3'(b + 1);

        logic [1:0]          re;
        logic [1:0][BW-1:0]  ra;
        logic [1:0][DW-1:0]  rd;

        assign re    = {hst_ok && (hst_sel == SEL), rd_ok && (csel == SEL)};
        assign ra[0] = caddr_rd[BW-1:0];
        assign ra[1] = hst_addr[BW-1:0];

        conv_bank_ram #(
            .DEPTH (BD),
            .DW    (DW),
            .AW    (BW),
            .NRD   (2)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (wr_ok && (csel == SEL)),
            .waddr (caddr_wr[BW-1:0]),
            .wdata (cdata_wr),
            .re    (re),
            .raddr (ra),
            .rdata (rd)
        );

        assign acc_q[b] = rd[0];
        assign hst_q[b] = rd[1];
    end

    // Source of each read-data output: a bank, or NOCEL meaning "drive zero".
    // Both hold across idle cycles, and so do the bank output registers.
    logic [2:0] cd_src, hs_src;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cd_src <= 3'(NOCEL);
            hs_src <= 3'(NOCEL);
        end else begin
            if (rd_ok) begin
                cd_src <= csel;
            end else if (rd_oor) begin
                cd_src <= 3'(NOCEL);
            end
            if (hst_ok) begin
                hs_src <= hst_sel;
            end else if (hst_oor) begin
                hs_src <= 3'(NOCEL);
            end
        end
    end

    always_comb begin
        cdata_rd  = '0;
        hst_rdata = '0;
        if (sel_valid(cd_src)) begin
            cdata_rd = acc_q[cd_src - 3'd1];
        end
        if (sel_valid(hs_src)) begin
            hst_rdata = hst_q[hs_src - 3'd1];
        end
    end

    // ---------------- session FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            run_cnt <= '0;
        end else begin
            state_q <= state_d;
            run_cnt <= (state_q == S_RUN) ? run_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        done    = 1'b0;
        timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                ready = 1'b1;
                if (busy) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!busy) begin
                    state_d = S_DONE;
                end else if (run_cnt == RW'(TIMEOUT_CYC - 1)) begin
                    timeout = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- errors and write counter ----------------
    logic [4:0] err_set;

    always_comb begin
        err_set              = '0;
        err_set[ERR_RW_BOTH] = cwr && crd;
        err_set[ERR_SEL]     = (cwr || crd) && !c_sel_ok;
        err_set[ERR_ADDR]    = wr_oor || rd_oor;
        err_set[ERR_IMG_WR]  = img_we && !img_ok;
        err_set[ERR_TIMEOUT] = timeout;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= '0;
            wr_count <= '0;
        end else begin
            err <= err | err_set;
            if (state_q == S_IDLE && start) begin
                wr_count <= '0;
            end else if (wr_ok && wr_count != 16'hFFFF) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_conv_host_mem.sv
// Self-checking bench for conv_host_mem: vector table, hand-written session
// sequences, then randomized traffic against a behavioural model.
module tb_conv_host_mem;

    localparam int TO = 600;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready, busy, cwr, crd, img_we, start, hst_rd, done;
    logic [11:0] iaddr, caddr_wr, caddr_rd, img_addr, hst_addr;
    logic [19:0] idata, cdata_wr, cdata_rd, img_wdata, hst_rdata;
    logic [2:0]  csel, hst_sel;
    logic [4:0]  err;
    logic [15:0] wr_count;

    conv_host_mem #(.DW(20), .AW(12), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ready(ready), .busy(busy),
        .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr),
        .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel),
        .img_we(img_we), .img_addr(img_addr), .img_wdata(img_wdata),
        .start(start), .hst_rd(hst_rd), .hst_sel(hst_sel), .hst_addr(hst_addr),
        .hst_rdata(hst_rdata), .done(done), .err(err), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Memory index 0 is the image, 1..5 the layer banks by csel code.
    logic [19:0] mem_m [6][4096];
    bit          kn_m  [6][4096];
    int          st_m;            // 0 idle, 1 requesting, 2 running, 3 done
    int          run_n;
    logic [4:0]  err_m;
    int          wc_m;
    logic [19:0] cd_m, hs_m, id_m;
    bit          cd_k, hs_k, id_k;

    function automatic int depth(input int s);
        case (s)
            1, 2:    return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        st_m = 0; run_n = 0; err_m = '0; wc_m = 0;
        cd_m = '0; hs_m = '0; id_m = '0;
        cd_k = 1'b1; hs_k = 1'b1; id_k = 1'b1;
    endtask

    task automatic clear_inputs();
        busy = 0; cwr = 0; crd = 0; img_we = 0; start = 0; hst_rd = 0;
        iaddr = '0; caddr_wr = '0; caddr_rd = '0; img_addr = '0; hst_addr = '0;
        cdata_wr = '0; img_wdata = '0; csel = '0; hst_sel = '0;
    endtask

    // Apply current inputs for one clock, advance the model, compare outputs.
    task automatic tick();
        int  s, h;
        bit  sok, hok, wacc;
        s = int'(csel); h = int'(hst_sel);
        sok = (s >= 1 && s <= 5);
        hok = (h >= 1 && h <= 5);
        wacc = 0;
        if (cwr && crd) err_m[0] = 1'b1;
        if ((cwr || crd) && !sok) err_m[1] = 1'b1;
        if (crd && !cwr && sok) begin
            if (int'(caddr_rd) < depth(s)) begin
                cd_m = mem_m[s][caddr_rd]; cd_k = kn_m[s][caddr_rd];
            end else begin
                cd_m = '0; cd_k = 1'b1; err_m[2] = 1'b1;
            end
        end
        if (hst_rd && hok) begin
            if (int'(hst_addr) < depth(h)) begin
                hs_m = mem_m[h][hst_addr]; hs_k = kn_m[h][hst_addr];
            end else begin
                hs_m = '0; hs_k = 1'b1;
            end
        end
        id_m = mem_m[0][iaddr]; id_k = kn_m[0][iaddr];
        if (cwr && sok) begin
            if (int'(caddr_wr) < depth(s)) begin
                mem_m[s][caddr_wr] = cdata_wr; kn_m[s][caddr_wr] = 1'b1; wacc = 1;
            end else begin
                err_m[2] = 1'b1;
            end
        end
        if (img_we) begin
            if (st_m == 0 || st_m == 3) begin
                mem_m[0][img_addr] = img_wdata; kn_m[0][img_addr] = 1'b1;
            end else begin
                err_m[3] = 1'b1;
            end
        end
        if (st_m == 0 && start) wc_m = 0;
        else if (wacc && wc_m < 65535) wc_m++;
        case (st_m)
            0: if (start) st_m = 1;
            1: if (busy) begin st_m = 2; run_n = 0; end
            2: begin
                run_n++;
                if (!busy) st_m = 3;
                else if (run_n == TO) begin st_m = 3; err_m[4] = 1'b1; end
            end
            default: st_m = 0;
        endcase
        @(posedge clk);
        #1;
        check("ready", 32'(ready), 32'(st_m == 1));
        check("done", 32'(done), 32'(st_m == 3));
        check("err", 32'(err), 32'(err_m));
        check("wr_count", 32'(wr_count), 32'(wc_m));
        if (cd_k) check("cdata_rd", 32'(cdata_rd), 32'(cd_m));
        if (hs_k) check("hst_rdata", 32'(hst_rdata), 32'(hs_m));
        if (id_k) check("idata", 32'(idata), 32'(id_m));
    endtask

    function automatic logic [11:0] pick(input logic [2:0] sel);
        int d;
        d = depth(int'(sel));
        case ($urandom_range(0, 6))
            0, 1, 2: return 12'($urandom_range(0, 3));
            3:       return (d > 0) ? 12'(d - 1) : 12'($urandom_range(0, 4095));
            4:       return (d > 0 && d < 4096) ? 12'(d) : 12'hFFF;
            5:       return 12'hFFF;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    typedef struct {
        bit          wr;
        bit          rd;
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] dat;
        logic [19:0] exp_cd;
        logic [4:0]  exp_err;
        int          exp_wc;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int cyc;
        tbl[0]  = '{1, 0, 3'd1, 12'hFFF, 20'h12345, 20'h00000, 5'h00, 1};
        tbl[1]  = '{0, 1, 3'd1, 12'hFFF, 20'h00000, 20'h12345, 5'h00, 1};
        tbl[2]  = '{1, 0, 3'd3, 12'h400, 20'h11111, 20'h12345, 5'h04, 1};
        tbl[3]  = '{1, 0, 3'd3, 12'h3FF, 20'h0ABCD, 20'h12345, 5'h04, 2};
        tbl[4]  = '{0, 1, 3'd3, 12'h3FF, 20'h00000, 20'h0ABCD, 5'h04, 2};
        tbl[5]  = '{0, 1, 3'd5, 12'h800, 20'h00000, 20'h00000, 5'h04, 2};
        tbl[6]  = '{1, 0, 3'd5, 12'h7FF, 20'h55555, 20'h00000, 5'h04, 3};
        tbl[7]  = '{0, 1, 3'd5, 12'h7FF, 20'h00000, 20'h55555, 5'h04, 3};
        tbl[8]  = '{1, 1, 3'd0, 12'h010, 20'h77777, 20'h55555, 5'h07, 3};
        tbl[9]  = '{1, 1, 3'd1, 12'hFFF, 20'h2468A, 20'h55555, 5'h07, 4};
        tbl[10] = '{0, 1, 3'd1, 12'hFFF, 20'h00000, 20'h2468A, 5'h07, 4};
        tbl[11] = '{0, 1, 3'd7, 12'h000, 20'h00000, 20'h2468A, 5'h07, 4};

        clear_inputs();
        model_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_wr_count", 32'(wr_count), 0);
        check("rst_cdata_rd", 32'(cdata_rd), 0);
        check("rst_hst_rdata", 32'(hst_rdata), 0);
        check("rst_idata", 32'(idata), 0);
        @(negedge clk);
        reset = 1'b1;

        // Vector table: layer accesses in IDLE.
        for (int i = 0; i < 12; i++) begin
            cwr = tbl[i].wr; crd = tbl[i].rd; csel = tbl[i].sel;
            caddr_wr = tbl[i].addr; caddr_rd = tbl[i].addr; cdata_wr = tbl[i].dat;
            tick();
            check($sformatf("tbl%0d_cdata_rd", i), 32'(cdata_rd), 32'(tbl[i].exp_cd));
            check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].exp_err));
            check($sformatf("tbl%0d_wr_count", i), 32'(wr_count), 32'(tbl[i].exp_wc));
        end
        clear_inputs();

        // Same-cycle write and host read of one address returns the old word.
        cwr = 1; csel = 3'd1; caddr_wr = 12'hFFF; cdata_wr = 20'h33333;
        hst_rd = 1; hst_sel = 3'd1; hst_addr = 12'hFFF;
        tick();
        check("rw_same_old", 32'(hst_rdata), 32'h2468A);
        cwr = 0; crd = 1; caddr_rd = 12'hFFF;
        tick();
        check("dual_rd_host", 32'(hst_rdata), 32'h33333);
        check("dual_rd_acc", 32'(cdata_rd), 32'h33333);
        clear_inputs();

        // Image load and read-back.
        img_we = 1; img_addr = 12'h041; img_wdata = 20'h0A89E;
        tick();
        img_we = 0; iaddr = 12'h041;
        tick();
        check("img_idata", 32'(idata), 32'h0A89E);

        // Session: start, handshake, accesses in RUN, busy falls.
        start = 1;
        tick();
        check("req_ready1", 32'(ready), 1);
        check("req_wc_clear", 32'(wr_count), 0);
        start = 0;
        tick();
        check("req_ready2", 32'(ready), 1);
        busy = 1;
        tick();
        check("run_ready0", 32'(ready), 0);
        img_we = 1; img_addr = 12'h100; img_wdata = 20'h00BAD; start = 1;
        tick();
        check("img_wr_in_run", 32'(err[3]), 1);
        img_we = 0; start = 0;
        cwr = 1; csel = 3'd1; caddr_wr = 12'hFFF; cdata_wr = 20'h12345;
        tick();
        cwr = 0; crd = 1; caddr_rd = 12'hFFF;
        tick();
        check("run_cdata_rd", 32'(cdata_rd), 32'h12345);
        check("run_wc1", 32'(wr_count), 1);
        crd = 0; cwr = 1; csel = 3'd3; caddr_wr = 12'h400;
        tick();
        check("oor_err2", 32'(err[2]), 1);
        check("oor_wc", 32'(wr_count), 1);
        cwr = 0;
        repeat (494) tick();
        busy = 0;
        tick();
        check("done_pulse", 32'(done), 1);
        check("no_timeout", 32'(err[4]), 0);
        hst_rd = 1; hst_sel = 3'd1; hst_addr = 12'hFFF;
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("host_readback", 32'(hst_rdata), 32'h12345);
        clear_inputs();

        // Timeout with busy stuck high.
        start = 1;
        tick();
        start = 0; busy = 1;
        tick();
        cyc = 0;
        for (int i = 1; i <= TO + 50; i++) begin
            tick();
            if (i == TO - 1) check("pre_timeout_err4", 32'(err[4]), 0);
            if (done) begin
                cyc = i;
                break;
            end
        end
        check("timeout_cycle", 32'(cyc), 32'(TO));
        check("timeout_err4", 32'(err[4]), 1);
        busy = 0;
        tick();

        // Reset mid-run: outputs clear at once, image survives.
        start = 1;
        tick();
        start = 0; busy = 1;
        repeat (6) tick();
        reset = 1'b0;
        #2;
        model_reset();
        check("mid_rst_ready", 32'(ready), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_cdata_rd", 32'(cdata_rd), 0);
        check("mid_rst_hst_rdata", 32'(hst_rdata), 0);
        check("mid_rst_idata", 32'(idata), 0);
        check("mid_rst_wr_count", 32'(wr_count), 0);
        @(negedge clk);
        reset = 1'b1;
        busy = 0; iaddr = 12'h041;
        tick();
        check("img_kept", 32'(idata), 32'h0A89E);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            csel     = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
            caddr_wr = pick(csel);
            caddr_rd = pick(csel);
            cwr      = ($urandom_range(0, 2) == 0);
            crd      = ($urandom_range(0, 1) == 1);
            cdata_wr = 20'($urandom);
            hst_sel  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(1, 5)) : 3'($urandom_range(0, 7));
            hst_addr = pick(hst_sel);
            hst_rd   = ($urandom_range(0, 1) == 1);
            iaddr    = 12'($urandom_range(12'h040, 12'h047));
            img_we   = ($urandom_range(0, 3) == 0);
            img_addr = 12'($urandom_range(12'h040, 12'h047));
            img_wdata = 20'($urandom);
            start    = ($urandom_range(0, 30) == 0);
            busy     = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
